// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: circular capture of probed stage values around a trigger,
// followed by an oldest-first valid/ready readout of the captured window.
module pipe_trace_buffer #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int TS_W      = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int EW = CHANNELS * WIDTH + CHANNELS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] probe_data,
  input  logic [CHANNELS-1:0]       probe_valid,
  input  logic                      sample_en,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [1:0]                trig_mode,
  input  logic                      trig_in,
  input  logic [CW-1:0]             trig_chan,
  input  logic [WIDTH-1:0]          trig_value,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [EW-1:0]             rd_data,
  output logic                      rd_last,
  output logic [TS_W-1:0]           trig_stamp,
  output logic [2:0]                state,
  output logic                      wrapped
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   POST_L    = AW'(POST_TRIG);
  localparam bit              POST_NONE = (POST_TRIG == 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3
  } state_t;

  state_t            state_r;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW:0]       fill_r;
  logic [TS_W-1:0]   ts_r;
  logic              wrapped_r;
  logic [AW-1:0]     post_cnt_r;
  logic [TS_W-1:0]   trig_stamp_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       rd_cnt_r;
  logic              rd_valid_r;
  logic              rd_last_r;
  logic [EW-1:0]     rd_data_r;

  logic [CHANNELS-1:0] hit_s;
  logic                trig_sel_s;
  logic                wr_en_s;
  logic                trig_s;
  logic                done_go_s;
  logic [AW-1:0]       wr_ptr_nx_s;
  logic [AW:0]         fill_nx_s;
  logic                wrapped_nx_s;
  logic [AW-1:0]       oldest_s;

  // Per-channel value match, only the selected channel can hit.
  always_comb begin
    hit_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      hit_s[i] = probe_valid[i] && (trig_chan == CW'(i)) &&
                 (probe_data[i*WIDTH +: WIDTH] == trig_value);
    end
  end

  // Trigger source selection.
  always_comb begin
    case (trig_mode)
      2'd0:    trig_sel_s = trig_in;
      2'd1:    trig_sel_s = |hit_s;
      2'd2:    trig_sel_s = trig_in | (|hit_s);
      default: trig_sel_s = 1'b0;
    endcase
  end

  assign wr_en_s      = ((state_r == ARMED) || (state_r == POST)) && sample_en && !abort && !reset;
  assign trig_s       = (state_r == ARMED) && wr_en_s && trig_sel_s;
  assign done_go_s    = wr_en_s && (((state_r == ARMED) && trig_s && POST_NONE) ||
                                    ((state_r == POST) && (post_cnt_r == AW'(1))));
  assign wr_ptr_nx_s  = wr_ptr_r + AW'(1);
  assign fill_nx_s    = (fill_r == DEPTH_L) ? fill_r : fill_r + (AW+1)'(1);
  assign wrapped_nx_s = wrapped_r | (fill_r == DEPTH_L);
  // After a wrap the slot about to be overwritten next holds the oldest sample.
  assign oldest_s     = wrapped_nx_s ? wr_ptr_nx_s : {AW{1'b0}};

  // Trace storage; contents are meaningless until written after an arm.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {probe_valid, probe_data};
    end
  end

  // Capture/readout controller with registered readout outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {AW{1'b0}};
      fill_r       <= {(AW+1){1'b0}};
      ts_r         <= {TS_W{1'b0}};
      wrapped_r    <= 1'b0;
      post_cnt_r   <= {AW{1'b0}};
      trig_stamp_r <= {TS_W{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      rd_cnt_r     <= {(AW+1){1'b0}};
      rd_valid_r   <= 1'b0;
      rd_last_r    <= 1'b0;
      rd_data_r    <= {EW{1'b0}};
    end else if (abort) begin
      state_r    <= IDLE;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arm) begin
            state_r   <= ARMED;
            wr_ptr_r  <= {AW{1'b0}};
            fill_r    <= {(AW+1){1'b0}};
            ts_r      <= {TS_W{1'b0}};
            wrapped_r <= 1'b0;
          end
        end
        ARMED, POST: begin
          ts_r <= ts_r + TS_W'(1);
          if (wr_en_s) begin
            wr_ptr_r  <= wr_ptr_nx_s;
            fill_r    <= fill_nx_s;
            wrapped_r <= wrapped_nx_s;
          end
          if ((state_r == POST) && wr_en_s) begin
            post_cnt_r <= post_cnt_r - AW'(1);
          end
          if (trig_s) begin
            trig_stamp_r <= ts_r;
          end
          if (done_go_s) begin
            state_r  <= DONE;
            rd_ptr_r <= oldest_s;
            rd_cnt_r <= fill_nx_s;
          end else if (trig_s) begin
            state_r    <= POST;
            post_cnt_r <= POST_L;
          end
        end
        DONE: begin
          if (rd_valid_r && rd_ready && rd_last_r) begin
            state_r    <= IDLE;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
          end else if ((!rd_valid_r || rd_ready) && (rd_cnt_r != {(AW+1){1'b0}})) begin
            rd_data_r  <= mem_r[rd_ptr_r];
            rd_last_r  <= (rd_cnt_r == (AW+1)'(1));
            rd_valid_r <= 1'b1;
            rd_ptr_r   <= rd_ptr_r + AW'(1);
            rd_cnt_r   <= rd_cnt_r - (AW+1)'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign rd_last    = rd_last_r;
  assign trig_stamp = trig_stamp_r;
  assign state      = state_r;
  assign wrapped    = wrapped_r;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: a behavioural capture model queues the
// expected trace window, readout pops and compares it entry by entry.
module tb_pipe_trace_buffer;

  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int D   = 8;
  localparam int PT  = 3;
  localparam int TSW = 16;
  localparam int EW  = CH * W + CH;

  logic            clock = 1'b0;
  logic            reset;
  logic [CH*W-1:0] probe_data;
  logic [CH-1:0]   probe_valid;
  logic            sample_en;
  logic            arm;
  logic            abort;
  logic [1:0]      trig_mode;
  logic            trig_in;
  logic [0:0]      trig_chan;
  logic [W-1:0]    trig_value;
  logic            rd_valid;
  logic            rd_ready;
  logic [EW-1:0]   rd_data;
  logic            rd_last;
  logic [TSW-1:0]  trig_stamp;
  logic [2:0]      state;
  logic            wrapped;

  pipe_trace_buffer #(
    .CHANNELS(CH), .WIDTH(W), .DEPTH(D), .POST_TRIG(PT), .TS_W(TSW)
  ) dut (
    .clock(clock), .reset(reset), .probe_data(probe_data), .probe_valid(probe_valid),
    .sample_en(sample_en), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_in(trig_in), .trig_chan(trig_chan), .trig_value(trig_value),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .trig_stamp(trig_stamp), .state(state), .wrapped(wrapped)
  );

  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int            m_state;
  int            m_ts;
  int            m_post;
  int            m_stamp;
  logic          m_wrapped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic model_trig(input logic [1:0] v, input logic [7:0] c0,
                                      input logic [7:0] c1, input logic tin);
    logic mt;
    mt = (trig_chan == 1'b1) ? (v[1] && (c1 == trig_value)) : (v[0] && (c0 == trig_value));
    case (trig_mode)
      2'd0:    return tin;
      2'd1:    return mt;
      2'd2:    return tin | mt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input logic en, input logic [1:0] v, input logic [7:0] c0,
                     input logic [7:0] c1, input logic tin);
    sample_en   = en;
    probe_valid = v;
    probe_data  = {c1, c0};
    trig_in     = tin;
    if (m_state == 1 || m_state == 2) begin
      if (en) begin
        exp_q.push_back({v, c1, c0});
        if (exp_q.size() > D) begin
          void'(exp_q.pop_front());
          m_wrapped = 1'b1;
        end
        if (m_state == 1 && model_trig(v, c0, c1, tin)) begin
          m_stamp = m_ts;
          m_post  = PT;
          m_state = (PT == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      m_ts++;
    end
    tick();
    check("state", 32'(state), 32'(m_state));
  endtask

  task automatic do_arm();
    arm = 1'b1; sample_en = 1'b0; trig_in = 1'b0;
    tick();
    arm = 1'b0;
    m_state = 1; m_ts = 0; m_wrapped = 1'b0;
    exp_q.delete();
    check("arm_state", 32'(state), 32'd1);
  endtask

  // Sample k carries ch0=k; gap_n idle cycles are inserted before sample gap_k.
  task automatic capture(input int trig_at, input int gap_k, input int gap_n);
    int k = 1;
    int gaps = gap_n;
    logic [7:0] c0, c1;
    logic [1:0] v;
    for (int g = 0; g < 40 && m_state != 3; g++) begin
      if (k == gap_k && gaps > 0) begin
        cyc(1'b0, 2'b11, 8'hEE, 8'hEE, 1'b1);
        gaps--;
      end else begin
        v  = (k == 3) ? 2'b01 : 2'b11;
        c0 = (trig_mode == 2'd1 && k == 4) ? 8'h5A : 8'(k);
        c1 = (k == 3 || k == 6) ? 8'h5A : 8'(k + 16);
        cyc(1'b1, v, c0, c1, k == trig_at);
        k++;
      end
    end
    sample_en = 1'b0; trig_in = 1'b0;
    check("done_state", 32'(state), 32'd3);
    check("trig_stamp", 32'(trig_stamp), 32'(m_stamp));
    check("wrapped", 32'(wrapped), 32'(m_wrapped));
    check("rd_valid_at_done", 32'(rd_valid), 32'd0);
  endtask

  task automatic readout(input int stall_at, input int stall_len);
    rd_ready = 1'b1;
    tick();
    for (int i = 0; exp_q.size() > 0 && i < D; i++) begin
      if (i == stall_at) begin
        rd_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_data", 32'(rd_data), 32'(exp_q[0]));
          check("stall_valid", 32'(rd_valid), 32'd1);
        end
        rd_ready = 1'b1;
      end
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", 32'(rd_data), 32'(exp_q[0]));
      check("rd_last", 32'(rd_last), 32'(exp_q.size() == 1));
      void'(exp_q.pop_front());
      tick();
    end
    m_state = 0;
    check("idle_after_last", 32'(state), 32'd0);
    check("rd_valid_after_last", 32'(rd_valid), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; probe_data = '0; probe_valid = '0; sample_en = 1'b0; arm = 1'b0;
    abort = 1'b0; trig_mode = 2'd0; trig_in = 1'b0; trig_chan = 1'b1;
    trig_value = 8'h5A; rd_ready = 1'b0;
    m_state = 0; m_ts = 0; m_post = 0; m_stamp = 0; m_wrapped = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_state", 32'(state), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_last", 32'(rd_last), 32'd0);
    check("reset_stamp", 32'(trig_stamp), 32'd0);
    check("reset_wrapped", 32'(wrapped), 32'd0);

    // External trigger on sample 10: window 6..13, wrapped.
    do_arm();
    capture(10, 0, 0);
    readout(-1, 0);

    // Early trigger on sample 2: window 1..5, no wrap.
    do_arm();
    capture(2, 0, 0);
    readout(-1, 0);

    // Channel-1 match: invalid 0x5A on sample 3 ignored, valid one on sample 6 fires.
    trig_mode = 2'd1;
    do_arm();
    capture(0, 0, 0);
    readout(-1, 0);

    // Idle sample_en cycles inside POST and a consumer stall mid-readout.
    trig_mode = 2'd0;
    do_arm();
    capture(4, 6, 2);
    readout(2, 4);

    // Abort during readout, then a clean recapture.
    do_arm();
    capture(2, 0, 0);
    rd_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("pre_abort_data", 32'(rd_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      tick();
    end
    abort = 1'b1; rd_ready = 1'b0;
    tick();
    abort = 1'b0;
    m_state = 0; exp_q.delete();
    check("abort_state", 32'(state), 32'd0);
    check("abort_rd_valid", 32'(rd_valid), 32'd0);
    do_arm();
    check("rearm_wrapped", 32'(wrapped), 32'd0);
    capture(2, 0, 0);
    readout(-1, 0);

    // Never-trigger mode keeps capturing circularly until abort.
    trig_mode = 2'd3;
    do_arm();
    for (int i = 0; i < 12; i++) cyc(1'b1, 2'b11, 8'(i), 8'h5A, 1'b1);
    check("mode3_wrapped", 32'(wrapped), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0; m_state = 0; exp_q.delete();
    check("mode3_abort_state", 32'(state), 32'd0);

    // Reset mid-capture discards everything; triggers without a new arm do nothing.
    trig_mode = 2'd0;
    do_arm();
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b11, 8'(i), 8'(i), 1'b0);
    check("pre_reset_wrapped", 32'(wrapped), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; m_state = 0; exp_q.delete();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_stamp", 32'(trig_stamp), 32'd0);
    check("midrst_wrapped", 32'(wrapped), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b11, 8'(i), 8'(i), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
